// File: rtl/dmem_bus_ctrl_if.sv
// Memory-side bus between dmem_bus_ctrl and a 32-bit req/ack memory.
// The controller is the master; the memory model is the slave.
interface dmem_bus_ctrl_if #(
  parameter int AW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
  logic          mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Splits one 64-bit core data access into one or two 32-bit req/ack bus beats,
// stalling the core via dataabort until the access is complete.
module dmem_bus_ctrl #(
  parameter int N       = 64,
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          datareq,
  input  logic [N-1:0]  dataadr,
  input  logic [N-1:0]  writedata,
  input  logic [1:0]    memwriteM,
  output logic [N-1:0]  readdata,
  output logic          dataabort,
  output logic          bus_err,
  output logic          align_err,
  dmem_bus_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  state_t         state, state_next;
  logic [AW-1:0]  adr_q;
  logic [N-1:0]   wdata_q;
  logic [1:0]     type_q;
  logic [CW-1:0]  wait_cnt;
  logic           in_beat;
  logic           two_beat;
  logic           timed_out;
  logic           misaligned;
  logic           unused_adr;

  assign unused_adr = ^dataadr[N-1:AW];

  assign in_beat    = (state == BEAT0) || (state == BEAT1);
  assign two_beat   = (type_q == 2'b00) || (type_q == 2'b11);
  assign timed_out  = (wait_cnt == CW'(TIMEOUT - 1));
  // Reads are force-aligned, so only word and doubleword stores can be misaligned.
  assign misaligned = ((memwriteM == 2'b11) && (dataadr[2:0] != 3'b000)) ||
                      ((memwriteM == 2'b01) && (dataadr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (datareq) state_next = misaligned ? DONE : BEAT0;
      BEAT0: begin
        if (bus.mem_ack)    state_next = two_beat ? BEAT1 : DONE;
        else if (timed_out) state_next = DONE;
      end
      BEAT1: if (bus.mem_ack || timed_out) state_next = DONE;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus signals are decoded from the latched access, so they stay stable through waits.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = 4'h0;
    bus.mem_wdata = 32'h0;
    dataabort     = reset && ((datareq && (state == IDLE)) || in_beat);
    if (in_beat) begin
      bus.mem_req = 1'b1;
      bus.mem_we  = (type_q != 2'b00);
      case (type_q)
        2'b01: begin
          bus.mem_addr  = {adr_q[AW-1:2], 2'b00};
          bus.mem_be    = 4'hF;
          bus.mem_wdata = wdata_q[31:0];
        end
        2'b10: begin
          bus.mem_addr  = {adr_q[AW-1:2], 2'b00};
          bus.mem_be    = 4'b0001 << adr_q[1:0];
          bus.mem_wdata = {4{wdata_q[7:0]}};
        end
        default: begin
          bus.mem_addr = {adr_q[AW-1:3], (state == BEAT1), 2'b00};
          bus.mem_be   = 4'hF;
          if (type_q == 2'b11)
            bus.mem_wdata = (state == BEAT1) ? wdata_q[63:32] : wdata_q[31:0];
        end
      endcase
    end
  end

  // readdata is cleared at acceptance so aborted or skipped lanes read back as zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr_q     <= '0;
      wdata_q   <= '0;
      type_q    <= 2'b00;
      wait_cnt  <= '0;
      readdata  <= '0;
      bus_err   <= 1'b0;
      align_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (datareq) begin
            adr_q    <= dataadr[AW-1:0];
            wdata_q  <= writedata;
            type_q   <= memwriteM;
            wait_cnt <= '0;
            readdata <= '0;
            if (misaligned) align_err <= 1'b1;
          end
        end
        BEAT0, BEAT1: begin
          if (bus.mem_ack) begin
            wait_cnt <= '0;
            if (type_q == 2'b00) begin
              if (state == BEAT0) readdata[31:0]  <= bus.mem_rdata;
              else                readdata[63:32] <= bus.mem_rdata;
            end
          end else if (timed_out) begin
            wait_cnt <= '0;
            bus_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: wait_cnt <= '0;
      endcase
    end
  end

endmodule
